// File: rtl/display_scan4.sv
// Four-digit multiplexed BCD display scanner with double-buffered digits.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module display_scan4 #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] dados,
    input  logic        carga,
    output logic [3:0]  bcd,
    output logic [3:0]  anodo,
    output logic        quadro
);

    localparam logic [19:0] LAST = 20'(SCAN_DIV - 1);

    logic [19:0] cnt;
    logic [1:0]  idx;
    logic [15:0] shadow;
    logic [15:0] active;
    logic        tick;
    logic        wrap;
    logic [1:0]  nidx;
    logic [15:0] nact;
    logic [3:0]  ndig;
    logic [3:0]  nan;
    logic [3:0]  lead;

    assign tick = (cnt == LAST);
    assign wrap = tick && (idx == 2'd3);
    assign nidx = idx + 2'd1;

    // Slot contents for the edge: new frame takes the fresh load or the shadow.
    always_comb begin
        nact = active;
        lead = 4'b0000;
        if (wrap) begin
            nact = carga ? dados : shadow;
        end
        ndig = nact[{nidx, 2'b00} +: 4];
        nan  = ~(4'b0001 << nidx);
`ifdef LEADING_ZERO_BLANK_EN
        lead[3] = (nact[15:12] == 4'd0);
        lead[2] = lead[3] && (nact[11:8] == 4'd0);
        lead[1] = lead[2] && (nact[7:4] == 4'd0);
        if (lead[nidx]) begin
            nan = 4'b1111;
        end
`endif
    end

    // Prescaler: counts 0..SCAN_DIV-1 and wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 20'd0;
        end else if (tick) begin
            cnt <= 20'd0;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    // Slot index advances on each tick; reset parks it on 3 so the first tick is a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd3;
        end else if (tick) begin
            idx <= nidx;
        end
    end

    // Shadow keeps the most recent load; active is refreshed only at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 16'h0000;
            active <= 16'h0000;
        end else begin
            if (carga) begin
                shadow <= dados;
            end
            active <= nact;
        end
    end

    // Registered outputs: digit and anode change on ticks, frame pulse follows the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd    <= 4'd0;
            anodo  <= 4'b1111;
            quadro <= 1'b0;
        end else begin
            quadro <= wrap;
            if (tick) begin
                bcd   <= ndig;
                anodo <= nan;
            end
        end
    end

endmodule
